// File: rtl/sand_spawner.sv
// Sand grain spawner: moves a cursor along the spawn row and injects a grain into the game-state RAM.
// Optional macro SAND_SPAWNER_JITTER_EN adds an LFSR-driven column offset (-1..+2) to each grain.
module sand_spawner #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int SPAWN_ROW      = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              tick_i,
    input  logic                              btn_left_i,
    input  logic                              btn_right_i,
    input  logic                              spawn_en_i,
    input  logic                              grant_i,
    input  logic [DATA_WIDTH-1:0]             ram_rd_data_i,
    output logic                              req_o,
    output logic [ADDR_WIDTH-1:0]             ram_rd_address_o,
    output logic [ADDR_WIDTH-1:0]             ram_wr_address_o,
    output logic [DATA_WIDTH-1:0]             ram_wr_data_o,
    output logic                              ram_wr_en_o,
    output logic [$clog2(ACTIVE_COLUMNS)-1:0] cursor_x_o,
    output logic                              busy_o,
    output logic [15:0]                       spawn_count_o
);

    localparam int CW = $clog2(ACTIVE_COLUMNS);
    localparam int ROW_SAFE = (SPAWN_ROW < ACTIVE_ROWS) ? SPAWN_ROW : ACTIVE_ROWS - 1;
    localparam logic [CW-1:0]         COL_MAX  = CW'(ACTIVE_COLUMNS - 1);
    localparam logic [CW-1:0]         COL_MID  = CW'(ACTIVE_COLUMNS / 2);
    localparam logic [CW-1:0]         COL_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] ROW_BASE = ADDR_WIDTH'(ROW_SAFE * ACTIVE_COLUMNS);
    localparam logic [DATA_WIDTH-1:0] GRAIN    = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        READ  = 3'd2,
        CHECK = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CW-1:0]           cursor_r;
    logic [CW-1:0]           cursor_next_s;
    logic [CW-1:0]           target_col_s;
    logic [ADDR_WIDTH-1:0]   target_addr_r;
    logic [15:0]             spawn_count_r;
    logic                    start_s;
    logic                    write_done_s;

    assign start_s      = (state_r == IDLE) && tick_i && spawn_en_i;
    assign write_done_s = (state_r == WRITE) && grant_i;

    // Cursor movement: one step per tick, opposing buttons cancel, no wrap at the edges.
    always_comb begin
        cursor_next_s = cursor_r;
        if (tick_i && btn_left_i && !btn_right_i && (cursor_r != {CW{1'b0}})) begin
            cursor_next_s = cursor_r - COL_ONE;
        end else if (tick_i && btn_right_i && !btn_left_i && (cursor_r != COL_MAX)) begin
            cursor_next_s = cursor_r + COL_ONE;
        end else begin
            cursor_next_s = cursor_r;
        end
    end

`ifdef SAND_SPAWNER_JITTER_EN
    logic [7:0]    lfsr_r;
    logic [CW+1:0] jit_sum_s;

    // Free-running LFSR for x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    // Cursor plus offset (lfsr[1:0]-1); the sum's top bit flags an underflow below column 0.
    always_comb begin
        jit_sum_s = {2'b00, cursor_r} + {{CW{1'b0}}, lfsr_r[1:0]} - {{(CW+1){1'b0}}, 1'b1};
        if (jit_sum_s[CW+1]) begin
            target_col_s = {CW{1'b0}};
        end else if (jit_sum_s > {2'b00, COL_MAX}) begin
            target_col_s = COL_MAX;
        end else begin
            target_col_s = jit_sum_s[CW-1:0];
        end
    end
`else
    // Without jitter the grain lands exactly under the cursor.
    always_comb begin
        target_col_s = cursor_r;
    end
`endif

    // Spawn sequencer next state; losing the grant anywhere past REQ abandons the grain.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = start_s ? REQ : IDLE;
            REQ:     state_next_s = grant_i ? READ : REQ;
            READ:    state_next_s = grant_i ? CHECK : IDLE;
            CHECK: begin
                if (!grant_i) begin
                    state_next_s = IDLE;
                end else if (ram_rd_data_i == {DATA_WIDTH{1'b0}}) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, cursor, latched target address and grain counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= IDLE;
            cursor_r      <= COL_MID;
            target_addr_r <= {ADDR_WIDTH{1'b0}};
            spawn_count_r <= 16'd0;
        end else begin
            state_r  <= state_next_s;
            cursor_r <= cursor_next_s;
            if (start_s) begin
                target_addr_r <= ROW_BASE + ADDR_WIDTH'(target_col_s);
            end
            if (write_done_s && (spawn_count_r != 16'hFFFF)) begin
                spawn_count_r <= spawn_count_r + 16'd1;
            end
        end
    end

    assign req_o            = (state_r != IDLE);
    assign busy_o           = (state_r != IDLE);
    assign ram_rd_address_o = (state_r == READ)  ? target_addr_r : {ADDR_WIDTH{1'b0}};
    assign ram_wr_address_o = (state_r == WRITE) ? target_addr_r : {ADDR_WIDTH{1'b0}};
    assign ram_wr_data_o    = (state_r == WRITE) ? GRAIN : {DATA_WIDTH{1'b0}};
    assign ram_wr_en_o      = write_done_s;
    assign cursor_x_o       = cursor_r;
    assign spawn_count_o    = spawn_count_r;

endmodule

// File: tb/tb_sand_spawner.sv
// Self-checking bench for sand_spawner (default build): cycle model plus directed literal checks.
module tb_sand_spawner;

    localparam int COLS      = 640;
    localparam int ROWS      = 480;
    localparam int AW        = $clog2(COLS * ROWS);
    localparam int DW        = 1;
    localparam int SPAWN_ROW = 0;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          tick_i = 1'b0;
    logic          btn_left_i = 1'b0;
    logic          btn_right_i = 1'b0;
    logic          spawn_en_i = 1'b0;
    logic          grant_i = 1'b0;
    logic [DW-1:0] ram_rd_data_i;
    logic          req_o;
    logic [AW-1:0] ram_rd_address_o;
    logic [AW-1:0] ram_wr_address_o;
    logic [DW-1:0] ram_wr_data_o;
    logic          ram_wr_en_o;
    logic [9:0]    cursor_x_o;
    logic          busy_o;
    logic [15:0]   spawn_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sand_spawner #(
        .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .SPAWN_ROW(SPAWN_ROW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i),
        .btn_left_i(btn_left_i), .btn_right_i(btn_right_i),
        .spawn_en_i(spawn_en_i), .grant_i(grant_i),
        .ram_rd_data_i(ram_rd_data_i), .req_o(req_o),
        .ram_rd_address_o(ram_rd_address_o), .ram_wr_address_o(ram_wr_address_o),
        .ram_wr_data_o(ram_wr_data_o), .ram_wr_en_o(ram_wr_en_o),
        .cursor_x_o(cursor_x_o), .busy_o(busy_o), .spawn_count_o(spawn_count_o)
    );

    // Game-state RAM with one-cycle read latency
    bit            mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        ram_q <= DW'(mem[ram_rd_address_o]);
        if (ram_wr_en_o) mem[ram_wr_address_o] <= ram_wr_data_o[0];
    end
    assign ram_rd_data_i = ram_q;

    // Behavioural model: m_step counts the cycles of an operation (0 none, 1 waiting for grant,
    // 2 address out, 3 data back, 4 write); m_occ remembers the cells the model expects filled.
    int m_cursor, m_step, m_target, m_count;
    bit m_occ [0:(1<<AW)-1];
    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_cursor <= COLS / 2;
            m_step   <= 0;
            m_target <= 0;
            m_count  <= 0;
        end else begin
            if (tick_i && btn_right_i && !btn_left_i)
                m_cursor <= (m_cursor + 1 > COLS - 1) ? COLS - 1 : m_cursor + 1;
            else if (tick_i && btn_left_i && !btn_right_i)
                m_cursor <= (m_cursor - 1 < 0) ? 0 : m_cursor - 1;
            case (m_step)
                0: if (tick_i && spawn_en_i) begin
                    m_step   <= 1;
                    m_target <= SPAWN_ROW * COLS + m_cursor;
                end
                1: if (grant_i) m_step <= 2;
                2: m_step <= grant_i ? 3 : 0;
                3: m_step <= (grant_i && !m_occ[m_target]) ? 4 : 0;
                4: begin
                    m_step <= 0;
                    if (grant_i) begin
                        m_occ[m_target] <= 1'b1;
                        m_count <= (m_count == 65535) ? 65535 : m_count + 1;
                    end
                end
                default: m_step <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Per-cycle comparison against the model, 1 time unit after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("m_req",     32'(req_o),            32'(m_step != 0));
            check("m_busy",    32'(busy_o),           32'(m_step != 0));
            check("m_wr_en",   32'(ram_wr_en_o),      32'((m_step == 4) && grant_i));
            check("m_wr_addr", 32'(ram_wr_address_o), (m_step == 4) ? m_target : 0);
            check("m_wr_data", 32'(ram_wr_data_o),    32'(m_step == 4));
            check("m_rd_addr", 32'(ram_rd_address_o), (m_step == 2) ? m_target : 0);
            check("m_cursor",  32'(cursor_x_o),       m_cursor);
            check("m_count",   32'(spawn_count_o),    m_count);
        end
    end

    // One tick pulse lasting a single cycle, starting and ending on a falling edge
    task automatic tick(input bit l, input bit r, input bit sp);
        tick_i = 1'b1; btn_left_i = l; btn_right_i = r; spawn_en_i = sp;
        @(negedge clk);
        tick_i = 1'b0; btn_left_i = 1'b0; btn_right_i = 1'b0; spawn_en_i = 1'b0;
    endtask

    initial begin
        #1 reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        check("rst_cursor", 32'(cursor_x_o), 32'd320);
        check("rst_count", 32'(spawn_count_o), 32'd0);
        check("rst_req", 32'(req_o), 32'd0);

        repeat (3) tick(1'b0, 1'b1, 1'b0);
        check("right3", 32'(cursor_x_o), 32'd323);
        tick(1'b1, 1'b1, 1'b0);
        check("both_hold", 32'(cursor_x_o), 32'd323);

        repeat (323) tick(1'b1, 1'b0, 1'b0);
        check("at_left", 32'(cursor_x_o), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        check("left_edge", 32'(cursor_x_o), 32'd0);
        repeat (639) tick(1'b0, 1'b1, 1'b0);
        check("at_right", 32'(cursor_x_o), 32'd639);
        tick(1'b0, 1'b1, 1'b0);
        check("right_edge", 32'(cursor_x_o), 32'd639);
        repeat (539) tick(1'b1, 1'b0, 1'b0);
        check("at_100", 32'(cursor_x_o), 32'd100);

        // empty cell with grant already high: write in the 4th cycle after the tick
        grant_i = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("spawn_wr_en", 32'(ram_wr_en_o), 32'd1);
        check("spawn_wr_addr", 32'(ram_wr_address_o), 32'd100);
        check("spawn_wr_data", 32'(ram_wr_data_o), 32'd1);
        @(negedge clk);
        check("spawn_count1", 32'(spawn_count_o), 32'd1);
        check("spawn_idle", 32'(busy_o), 32'd0);

        // same cell again: now occupied, no write
        tick(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("occ_check_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("occ_idle", 32'(busy_o), 32'd0);
        check("occ_no_wr", 32'(ram_wr_en_o), 32'd0);
        check("occ_count", 32'(spawn_count_o), 32'd1);

        // grant withheld for 10 cycles; a tick during the wait moves the cursor only
        tick(1'b0, 1'b1, 1'b0);
        grant_i = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        check("wait_req0", 32'(req_o), 32'd1);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                tick_i = 1'b1; btn_right_i = 1'b1; spawn_en_i = 1'b1;
            end
            @(negedge clk);
            tick_i = 1'b0; btn_right_i = 1'b0; spawn_en_i = 1'b0;
            check("wait_req", 32'(req_o), 32'd1);
        end
        check("wait_cursor", 32'(cursor_x_o), 32'd102);
        grant_i = 1'b1;
        repeat (3) @(negedge clk);
        check("late_wr_en", 32'(ram_wr_en_o), 32'd1);
        check("late_wr_addr", 32'(ram_wr_address_o), 32'd101);
        @(negedge clk);
        check("late_count", 32'(spawn_count_o), 32'd2);
        check("late_req", 32'(req_o), 32'd0);

        // grant lost in CHECK
        tick(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        grant_i = 1'b0;
        #1 check("drop_chk_wr", 32'(ram_wr_en_o), 32'd0);
        @(negedge clk);
        check("drop_chk_req", 32'(req_o), 32'd0);
        check("drop_chk_count", 32'(spawn_count_o), 32'd2);
        grant_i = 1'b1;

        // grant lost in WRITE: strobe suppressed that same cycle
        tick(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        grant_i = 1'b0;
        #1 check("drop_wr_en", 32'(ram_wr_en_o), 32'd0);
        check("drop_wr_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("drop_wr_idle", 32'(busy_o), 32'd0);
        check("drop_wr_count", 32'(spawn_count_o), 32'd2);
        grant_i = 1'b1;

        // cell 102 still empty after both aborts
        tick(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("retry_wr_en", 32'(ram_wr_en_o), 32'd1);
        check("retry_wr_addr", 32'(ram_wr_address_o), 32'd102);
        @(negedge clk);
        check("retry_count", 32'(spawn_count_o), 32'd3);

        // reset during CHECK
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("rc_cursor", 32'(cursor_x_o), 32'd320);
        check("rc_count", 32'(spawn_count_o), 32'd0);
        check("rc_req", 32'(req_o), 32'd0);
        check("rc_busy", 32'(busy_o), 32'd0);
        check("rc_wr_en", 32'(ram_wr_en_o), 32'd0);
        check("rc_rd_addr", 32'(ram_rd_address_o), 32'd0);
        check("rc_wr_addr", 32'(ram_wr_address_o), 32'd0);
        check("rc_wr_data", 32'(ram_wr_data_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("rc_after_wr", 32'(ram_wr_en_o), 32'd0);
        check("rc_after_busy", 32'(busy_o), 32'd0);
        check("rc_mem103", 32'(mem[103]), 32'd0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sand_spawner.md
SAND_SPAWNER -- requirements
Module: sand_spawner

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter ACTIVE_COLUMNS, default 640: playfield width in cells.
REQ-003 Parameter ACTIVE_ROWS, default 480: playfield height in cells.
REQ-004 Parameter ADDR_WIDTH, default $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS): game-state RAM address width.
REQ-005 Parameter DATA_WIDTH, default 1: game-state RAM cell width.
REQ-006 Parameter SPAWN_ROW, default 0: row where grains are injected.
REQ-007 Ports SHALL be, in this order:
 clk_i  in  1  system clock
 reset_i  in  1  async active-high reset
 tick_i  in  1  one-cycle step pulse from tick speed logic
 btn_left_i  in  1  move cursor left on tick
 btn_right_i  in  1  move cursor right on tick
 spawn_en_i  in  1  spawn request level, sampled on tick
 grant_i  in  1  RAM access granted by game state controller
 ram_rd_data_i  in  DATA_WIDTH  game-state RAM read data, 1-cycle latency
 req_o  out  1  RAM access request
 ram_rd_address_o  out  ADDR_WIDTH  read address
 ram_wr_address_o  out  ADDR_WIDTH  write address
 ram_wr_data_o  out  DATA_WIDTH  write data
 ram_wr_en_o  out  1  write strobe
 cursor_x_o  out  $clog2(ACTIVE_COLUMNS)  current cursor column
 busy_o  out  1  FSM not in IDLE
 spawn_count_o  out  16  grains written since reset

Function
REQ-008 Cursor update on tick_i only: left-only and cursor>0 -> decrement; right-only and cursor<ACTIVE_COLUMNS-1 -> increment; both or neither pressed -> hold; at edges -> hold (no wrap).
REQ-009 FSM states SHALL be IDLE, REQ, READ, CHECK, WRITE.
REQ-010 IDLE -> REQ when tick_i=1 and spawn_en_i=1; target column latched from cursor value before that tick's cursor update.
REQ-011 tick_i pulses while busy_o=1 SHALL be dropped for spawning but still move the cursor.
REQ-012 REQ: req_o=1; advance to READ on the first cycle grant_i=1.
REQ-013 req_o SHALL remain 1 in READ, CHECK, WRITE and drop to 0 on the cycle after WRITE (return to IDLE).
REQ-014 Target address = SPAWN_ROW*ACTIVE_COLUMNS + target column, computed at ADDR_WIDTH, held constant through the operation.
REQ-015 READ: ram_rd_address_o = target address for exactly one cycle; CHECK samples ram_rd_data_i.
REQ-016 CHECK: data all-zero -> WRITE; non-zero -> IDLE with no write (cell occupied).
REQ-017 WRITE: ram_wr_en_o=1 for exactly one cycle, ram_wr_address_o = target, ram_wr_data_o = 1 (LSB set, other bits 0).
REQ-018 grant_i deasserting in READ, CHECK or WRITE SHALL abort to IDLE that cycle with ram_wr_en_o=0.
REQ-019 spawn_count_o increments once per completed write, saturating at 16'hFFFF.
REQ-020 Trigger-to-write latency with grant already high: 4 cycles (REQ, READ, CHECK, WRITE).
REQ-021 ram_wr_en_o SHALL be 0 in every state except WRITE.

Reset
REQ-022 reset_i asserted, any state: FSM -> IDLE, cursor_x_o=ACTIVE_COLUMNS/2, req_o=0, ram_wr_en_o=0, addresses=0, ram_wr_data_o=0, busy_o=0, spawn_count_o=0.
REQ-023 Reset mid-operation SHALL suppress any pending write; no write occurs in the cycle reset deasserts.

Configuration
REQ-024 Macro SAND_SPAWNER_JITTER_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advances every cycle) adds offset lfsr[1:0]-1 (range -1..+2) to the latched column, clamped to [0, ACTIVE_COLUMNS-1].
REQ-025 Macro undefined: no LFSR; target column equals latched cursor exactly.

Verification
REQ-026 Reset released, 3 ticks with btn_right_i=1 -> cursor_x_o=323; 1 tick with both buttons -> 323.
REQ-027 Cursor=0, tick with btn_left_i=1 -> stays 0; cursor=639, btn_right_i -> stays 639.
REQ-028 Macro undefined, cursor=100, grant_i=1, empty cell, spawn tick -> ram_wr_en_o pulse 4 cycles later at address 100, data 1, spawn_count_o=1.
REQ-029 Same with ram_rd_data_i=1 in CHECK -> no write, spawn_count_o unchanged, busy_o=0 after CHECK.
REQ-030 grant_i held 0 for 10 cycles then 1 -> req_o high throughout, write 3 cycles after grant; grant_i dropped in CHECK -> no write, req_o=0 next cycle.
REQ-031 reset_i asserted during CHECK -> no ram_wr_en_o pulse, all outputs at REQ-022 values.
